// File: rtl/angle_range_reducer.sv
//==============================================================================
// Module      : angle_range_reducer
// Description : Reduces a floating-point angle (radians) to [0, 2*PI) or
//               [-PI, PI] by repeated subtraction through a shared adder.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module angle_range_reducer #(
    parameter int                    EXP_LEN      = 8,
    parameter int                    MANTISSA_LEN = 23,
    parameter int                    EXP_BIAS     = 2**(EXP_LEN-1)-1,
    parameter logic [MANTISSA_LEN-1:0] PI_MANTISSA = 23'h490FDB,
    parameter int                    MAX_ITER     = 160
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0]     in_angle,
    input  logic                              in_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]     out_angle,
    output logic                              out_invalid,
    output logic                              out_overflow,
    output logic [EXP_LEN+MANTISSA_LEN:0]     add_a,
    output logic [EXP_LEN+MANTISSA_LEN:0]     add_b,
    output logic                              add_start,
    input  logic [EXP_LEN+MANTISSA_LEN:0]     add_sum,
    input  logic                              add_ready
);

    localparam int c_w     = EXP_LEN + MANTISSA_LEN + 1;
    localparam int c_cnt_w = $clog2(MAX_ITER + 1);

    localparam logic [EXP_LEN-1:0] c_exp_pi  = EXP_LEN'(EXP_BIAS + 1);
    localparam logic [EXP_LEN-1:0] c_exp_2pi = EXP_LEN'(EXP_BIAS + 2);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_ITER);
    localparam logic [c_w-1:0]     c_quiet   = c_w'(1) << (MANTISSA_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLASSIFY  = 3'd1,
        S_CHECK     = 3'd2,
        S_SUB_ISSUE = 3'd3,
        S_SUB_WAIT  = 3'd4,
        S_FIX       = 3'd5,
        S_FIX_WAIT  = 3'd6,
        S_OUTPUT    = 3'd7
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sign, w_sign_nxt;
    logic                r_mode, w_mode_nxt;
    logic                r_flip, w_flip_nxt;
    logic [c_w-1:0]      r_m, w_m_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [c_w-1:0]      r_out_angle, w_out_angle_nxt;
    logic                r_out_invalid, w_out_invalid_nxt;
    logic                r_out_overflow, w_out_overflow_nxt;
    logic [c_w-1:0]      r_add_a, w_add_a_nxt;
    logic [c_w-1:0]      r_add_b, w_add_b_nxt;
    logic                r_add_start, w_add_start_nxt;

    logic [EXP_LEN-1:0]      w_exp, w_exp_sub;
    logic [MANTISSA_LEN-1:0] w_frac;
    logic                    w_ge_2pi, w_gt_pi;

    assign w_exp  = r_m[c_w-2:MANTISSA_LEN];
    assign w_frac = r_m[MANTISSA_LEN-1:0];

    // Scaled 2*PI*2^j with j chosen so the subtrahend never exceeds m.
    assign w_exp_sub = (w_frac >= PI_MANTISSA) ? w_exp : (w_exp - EXP_LEN'(1));
    assign w_ge_2pi  = (w_exp > c_exp_2pi) || ((w_exp == c_exp_2pi) && (w_frac >= PI_MANTISSA));
    assign w_gt_pi   = (w_exp == c_exp_2pi) || ((w_exp == c_exp_pi) && (w_frac > PI_MANTISSA));

    always_comb begin
        w_state_nxt        = r_state;
        w_sign_nxt         = r_sign;
        w_mode_nxt         = r_mode;
        w_flip_nxt         = r_flip;
        w_m_nxt            = r_m;
        w_cnt_nxt          = r_cnt;
        w_out_angle_nxt    = r_out_angle;
        w_out_invalid_nxt  = r_out_invalid;
        w_out_overflow_nxt = r_out_overflow;
        w_add_a_nxt        = r_add_a;
        w_add_b_nxt        = r_add_b;
        w_add_start_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_sign_nxt         = in_angle[c_w-1];
                    w_m_nxt            = {1'b0, in_angle[c_w-2:0]};
                    w_mode_nxt         = in_mode;
                    w_cnt_nxt          = '0;
                    w_out_invalid_nxt  = 1'b0;
                    w_out_overflow_nxt = 1'b0;
                    w_state_nxt        = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (w_exp == '1) begin
                    w_out_angle_nxt   = {r_sign, r_m[c_w-2:0]} | c_quiet;
                    w_out_invalid_nxt = 1'b1;
                    w_state_nxt       = S_OUTPUT;
                end else if (w_exp == '0) begin
                    w_m_nxt         = '0;
                    w_out_angle_nxt = '0;
                    w_state_nxt     = S_OUTPUT;
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_ge_2pi) begin
                    if (r_cnt == c_max_cnt) begin
                        w_out_angle_nxt    = r_m;
                        w_out_overflow_nxt = 1'b1;
                        w_state_nxt        = S_OUTPUT;
                    end else begin
                        w_state_nxt = S_SUB_ISSUE;
                    end
                end else begin
                    w_state_nxt = S_FIX;
                end
            end
            S_SUB_ISSUE: begin
                w_add_a_nxt     = r_m;
                w_add_b_nxt     = {1'b1, w_exp_sub, PI_MANTISSA};
                w_add_start_nxt = 1'b1;
                w_cnt_nxt       = r_cnt + c_cnt_w'(1);
                w_state_nxt     = S_SUB_WAIT;
            end
            S_SUB_WAIT: begin
                if (add_ready) begin
                    w_m_nxt     = add_sum;
                    w_state_nxt = S_CHECK;
                end
            end
            S_FIX: begin
                if (!r_mode) begin
                    if (!r_sign) begin
                        w_out_angle_nxt = r_m;
                        w_state_nxt     = S_OUTPUT;
                    end else if (r_m[c_w-2:0] == '0) begin
                        w_out_angle_nxt = '0;
                        w_state_nxt     = S_OUTPUT;
                    end else begin
                        w_add_a_nxt     = {1'b0, c_exp_2pi, PI_MANTISSA};
                        w_add_b_nxt     = {1'b1, r_m[c_w-2:0]};
                        w_flip_nxt      = 1'b0;
                        w_add_start_nxt = 1'b1;
                        w_state_nxt     = S_FIX_WAIT;
                    end
                end else if (!w_gt_pi) begin
                    w_out_angle_nxt = {r_sign, r_m[c_w-2:0]};
                    w_state_nxt     = S_OUTPUT;
                end else begin
                    // Negative inputs mirror the positive result: -(m - 2*PI).
                    w_add_a_nxt     = r_m;
                    w_add_b_nxt     = {1'b1, c_exp_2pi, PI_MANTISSA};
                    w_flip_nxt      = r_sign;
                    w_add_start_nxt = 1'b1;
                    w_state_nxt     = S_FIX_WAIT;
                end
            end
            S_FIX_WAIT: begin
                if (add_ready) begin
                    w_out_angle_nxt = {add_sum[c_w-1] ^ r_flip, add_sum[c_w-2:0]};
                    w_state_nxt     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    w_out_invalid_nxt  = 1'b0;
                    w_out_overflow_nxt = 1'b0;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sign         <= 1'b0;
            r_mode         <= 1'b0;
            r_flip         <= 1'b0;
            r_m            <= '0;
            r_cnt          <= '0;
            r_out_angle    <= '0;
            r_out_invalid  <= 1'b0;
            r_out_overflow <= 1'b0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_start    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sign         <= w_sign_nxt;
            r_mode         <= w_mode_nxt;
            r_flip         <= w_flip_nxt;
            r_m            <= w_m_nxt;
            r_cnt          <= w_cnt_nxt;
            r_out_angle    <= w_out_angle_nxt;
            r_out_invalid  <= w_out_invalid_nxt;
            r_out_overflow <= w_out_overflow_nxt;
            r_add_a        <= w_add_a_nxt;
            r_add_b        <= w_add_b_nxt;
            r_add_start    <= w_add_start_nxt;
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_OUTPUT);
    assign out_angle    = r_out_angle;
    assign out_invalid  = r_out_invalid;
    assign out_overflow = r_out_overflow;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_start    = r_add_start;

endmodule

`default_nettype wire

// File: tb/tb_angle_range_reducer.sv
//==============================================================================
// Module      : tb_angle_range_reducer
// Description : Directed self-checking bench for angle_range_reducer.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_angle_range_reducer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_valid2 = 1'b0;
    logic [31:0] in_angle = '0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] add_sum = '0;
    logic        add_ready = 1'b0;

    logic        in_ready, out_valid, out_invalid, out_overflow, add_start;
    logic [31:0] out_angle, add_a, add_b;
    logic        in_ready2, out_valid2, out_invalid2, out_overflow2, add_start2;
    logic [31:0] out_angle2, add_a2, add_b2;

    always #5 clk = ~clk;

    angle_range_reducer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle),
        .out_invalid(out_invalid), .out_overflow(out_overflow),
        .add_a(add_a), .add_b(add_b), .add_start(add_start),
        .add_sum(add_sum), .add_ready(add_ready)
    );

    angle_range_reducer #(.MAX_ITER(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_angle(in_angle), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_angle(out_angle2),
        .out_invalid(out_invalid2), .out_overflow(out_overflow2),
        .add_a(add_a2), .add_b(add_b2), .add_start(add_start2),
        .add_sum(add_sum), .add_ready(add_ready)
    );

    int checks = 0, passes = 0, fails = 0;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] mt;
        int          fe;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        fe = int'(d[62:52]) - 1023 + 127;
        mt = {2'b01, d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || mt[0])) mt = mt + 25'd1;
        if (mt[24]) begin
            mt = mt >> 1;
            fe = fe + 1;
        end
        return {d[63], fe[7:0], mt[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Adder model shared by both instances; only one is ever busy at a time.
    int          lat = 2;
    int          acnt = 0;
    int          n_starts = 0;
    int          start_viol = 0;
    logic        prev_start = 1'b0;
    logic [31:0] pend_sum = '0;
    logic [31:0] b_log [0:7];
    logic        m_start;
    logic [31:0] m_a, m_b;

    assign m_start = add_start | add_start2;
    assign m_a     = add_start2 ? add_a2 : add_a;
    assign m_b     = add_start2 ? add_b2 : add_b;

    always @(negedge clk) begin
        add_ready = 1'b0;
        if (acnt > 0) begin
            acnt = acnt - 1;
            if (acnt == 0) begin
                add_ready = 1'b1;
                add_sum   = pend_sum;
            end
        end
        if (m_start) begin
            if (prev_start) start_viol = start_viol + 1;
            if (n_starts < 8) b_log[n_starts] = m_b;
            n_starts = n_starts + 1;
            pend_sum = fadd(m_a, m_b);
            acnt     = lat;
        end
        prev_start = m_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input real exp_r, input int tol);
        logic [31:0] e;
        int          d;
        e = r2f(exp_r);
        d = int'(obs[30:0]) - int'(e[30:0]);
        if (d < 0) d = -d;
        checks++;
        assert ((obs[31] === e[31]) && (d <= tol)) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (+/-%0d ulp)", tag, obs, e, tol);
        end
    endtask

    task automatic xact(input bit sel, input logic [31:0] a, input logic m, input int hold,
                        output logic [31:0] res, output logic inv, output logic ovf);
        int t;
        t = 0;
        @(negedge clk);
        while (!(sel ? in_ready2 : in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_starts = 0;
        in_angle = a;
        in_mode  = m;
        if (sel) in_valid2 = 1'b1;
        else     in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        t = 0;
        while (!(sel ? out_valid2 : out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_timeout", 32'(t < 3000), 32'd1);
        res = sel ? out_angle2 : out_angle;
        inv = sel ? out_invalid2 : out_invalid;
        ovf = sel ? out_overflow2 : out_overflow;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("out_valid_held", 32'(out_valid), 32'd1);
            chk("out_angle_held", out_angle, res);
            chk("in_ready_while_held", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_cleared", 32'(sel ? out_valid2 : out_valid), 32'd0);
    endtask

    logic [31:0] res;
    logic        inv, ovf;

    // Expected approximations use the float-rounded 2*PI (6.28318548).
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_out_angle", out_angle, 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_flags", {30'd0, out_invalid, out_overflow}, 32'd0);
        reset = 1'b0;

        xact(1'b0, 32'h3F800000, 1'b0, 3, res, inv, ovf);
        chk("one_m0", res, 32'h3F800000);
        chk("one_m0_adds", 32'(n_starts), 32'd0);

        xact(1'b0, 32'hBF800000, 1'b0, 0, res, inv, ovf);
        chk_tol("neg_one_m0", res, 5.2831855, 1);
        chk("neg_one_m0_adds", 32'(n_starts), 32'd1);

        lat = 3;
        xact(1'b0, 32'h42C80000, 1'b0, 0, res, inv, ovf);
        lat = 2;
        chk_tol("hundred_m0", res, 5.7522178, 4);
        chk("hundred_adds", 32'(n_starts), 32'd4);
        chk("hundred_b0", b_log[0], 32'hC2490FDB);
        chk("hundred_b1", b_log[1], 32'hC1C90FDB);
        chk("hundred_b2", b_log[2], 32'hC1490FDB);
        chk("hundred_b3", b_log[3], 32'hC0C90FDB);
        chk("hundred_ovf", 32'(ovf), 32'd0);

        xact(1'b0, 32'h40800000, 1'b1, 0, res, inv, ovf);
        chk_tol("four_m1", res, -2.2831855, 2);
        xact(1'b0, 32'hC0800000, 1'b1, 0, res, inv, ovf);
        chk_tol("neg_four_m1", res, 2.2831855, 2);
        xact(1'b0, 32'h40E00000, 1'b1, 0, res, inv, ovf);
        chk_tol("seven_m1", res, 0.7168145, 4);
        chk("seven_adds", 32'(n_starts), 32'd1);
        xact(1'b0, 32'h40400000, 1'b1, 0, res, inv, ovf);
        chk("three_m1", res, 32'h40400000);
        chk("three_adds", 32'(n_starts), 32'd0);

        // Abandon a transaction while the adder is busy.
        lat = 6;
        @(negedge clk);
        n_starts = 0;
        in_angle = 32'h42C80000;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 50 && n_starts == 0; t++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_test_started", 32'(n_starts), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_add_a", add_a, 32'd0);
        chk("midrst_add_b", add_b, 32'd0);
        chk("midrst_out_angle", out_angle, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        chk("postrst_no_new_adds", 32'(n_starts), 32'd1);
        lat = 2;

        xact(1'b0, 32'h3F800000, 1'b0, 0, res, inv, ovf);
        chk("after_rst_one", res, 32'h3F800000);

        xact(1'b0, 32'h7F800000, 1'b0, 0, res, inv, ovf);
        chk("inf_angle", res, 32'h7FC00000);
        chk("inf_invalid", 32'(inv), 32'd1);
        chk("inf_adds", 32'(n_starts), 32'd0);

        xact(1'b0, 32'h00000001, 1'b0, 0, res, inv, ovf);
        chk("denorm_angle", res, 32'h00000000);
        chk("denorm_invalid", 32'(inv), 32'd0);

        xact(1'b1, 32'h42C80000, 1'b0, 0, res, inv, ovf);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_adds", 32'(n_starts), 32'd2);

        chk("add_start_never_back_to_back", 32'(start_viol), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/angle_range_reducer.md
Name: angle_range_reducer

Overview:
- Parametrised successor to the single-range angle normaliser. Reduces an IEEE-style floating-point angle in radians to a range chosen per transaction: mode 0 gives [0, 2*PI), mode 1 gives [-PI, PI].
- Uses an external shared floating-point adder through the start/ready handshake the codebase already uses.
- Takes input through valid/ready and holds the output until the consumer accepts it.
- Classifies special operands and bounds the iteration count.

Parameters:
- EXP_LEN, 8: number of exponent bits.
- MANTISSA_LEN, 23: number of stored mantissa bits.
- EXP_BIAS, 2**(EXP_LEN-1)-1: exponent bias.
- PI_MANTISSA, 23'h490FDB: stored mantissa of PI, MANTISSA_LEN bits. PI exponent = EXP_BIAS+1; 2*PI exponent = EXP_BIAS+2.
- MAX_ITER, 160: maximum subtract iterations before the reduction aborts. Width of the iteration counter = clog2(MAX_ITER+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input angle valid.
- in_ready  out  1  block idle and able to accept.
- in_angle  in  W=EXP_LEN+MANTISSA_LEN+1  {sign, exp, mantissa}.
- in_mode  in  1  0 = [0, 2*PI), 1 = [-PI, PI].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- out_angle  out  W  normalised angle.
- out_invalid  out  1  input was NaN or Inf.
- out_overflow  out  1  MAX_ITER was reached; out_angle is the partial remainder.
- add_a  out  W  adder operand a.
- add_b  out  W  adder operand b.
- add_start  out  1  one-cycle start pulse to the adder.
- add_sum  in  W  adder result, a+b.
- add_ready  in  1  add_sum is valid this cycle.

Behaviour:
- Reset (async, active-high) forces all of the following:
  - state = IDLE, in_ready = 1.
  - out_valid, out_angle, out_invalid, out_overflow, add_a, add_b, add_start, iteration counter = 0.
  - Reset mid-operation abandons the transaction. Any add_ready arriving afterwards is ignored while in IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch sign s, magnitude m = {0, exp, mant} and mode; clear the counter; in_ready drops next cycle; go to CLASSIFY.
- CLASSIFY:
  - exp all-ones: out_angle = in_angle with quiet bit (mantissa MSB) set, out_invalid = 1, go to OUTPUT.
  - exp == 0 (zero or denormal): m = +0, go to OUTPUT.
  - Otherwise go to CHECK.
- CHECK (e = exp(m), f = mant(m)):
  - If e > EXP_BIAS+2, or (e == EXP_BIAS+2 and f >= PI_MANTISSA), m >= 2*PI: go to SUB_ISSUE.
  - Else go to FIX.
  - If the counter == MAX_ITER while m >= 2*PI: set out_overflow, go to OUTPUT.
- SUB_ISSUE:
  - add_a = m, add_b = {1, e_sub, PI_MANTISSA}.
  - e_sub = e when f >= PI_MANTISSA, else e-1. This subtracts the largest 2*PI*2^j that is <= m.
  - add_start = 1 for exactly one cycle; counter += 1; go to SUB_WAIT.
- SUB_WAIT:
  - add_start = 0.
  - On add_ready: m = add_sum, go to CHECK.
  - add_ready in the same cycle as add_start is not expected; the adder latency is >= 1 cycle.
- FIX (m in [0, 2*PI)); gt_pi = (e == EXP_BIAS+2) or (e == EXP_BIAS+1 and f > PI_MANTISSA):
  - mode 0, s = 0: result = m, go to OUTPUT.
  - mode 0, s = 1, m == 0: result = +0, go to OUTPUT.
  - mode 0, s = 1, m != 0: issue add_a = {0, EXP_BIAS+2, PI_MANTISSA}, add_b = {1, m[W-2:0]}; result = 2*PI - m.
  - mode 1, gt_pi = 0: result = {s, m[W-2:0]}, go to OUTPUT.
  - mode 1, gt_pi = 1: issue add_a = m, add_b = {1, EXP_BIAS+2, PI_MANTISSA}; result = m - 2*PI, with the sign bit inverted when s = 1.
  - Each issue is a one-cycle add_start, then FIX_WAIT until add_ready. The result is latched in the add_ready cycle, then go to OUTPUT.
- OUTPUT:
  - out_valid = 1; out_angle, out_invalid and out_overflow are held stable.
  - In the cycle where out_valid && out_ready: out_valid = 0, flags clear, go to IDLE.
  - in_ready rises the following cycle. No bypass from the output to the next input.
- Invariants:
  - At most one adder operation outstanding.
  - add_start is never high in two consecutive cycles.
  - in_ready and out_valid are never both 1.
- Precision: every subtract is performed by the external adder. Accuracy loss for large |x| is accepted and is not compensated.

Test Plan:
- in_angle = 0x3F800000 (1.0), mode 0 -> out_angle 0x3F800000, no add_start, out_valid held 3 cycles while out_ready = 0.
- -1.0, mode 0 -> one adder op, out_angle within 1 ulp of 5.2831853, sign 0.
- 100.0, mode 0, adder model latency 3 -> exactly 4 subtracts (b = 50.27, 25.13, 12.57, 6.28); out_angle ≈ 5.752220 (within 4 ulp).
- 4.0 mode 1 -> ≈ -2.2831853. -4.0 mode 1 -> ≈ +2.2831853. 7.0 mode 1 -> ≈ 0.7168147. 3.0 mode 1 -> 0x40400000 with no adder op.
- 0x7F800000 (+Inf) -> out_invalid = 1, out_angle 0x7FC00000, no add_start. 0x00000001 (denormal) -> out_angle 0x00000000.
- Overflow and reset:
  - MAX_ITER = 2 with in_angle 100.0 -> out_overflow = 1 after 2 subtracts.
  - Assert reset during SUB_WAIT, then return add_ready -> outputs at reset values, in_ready = 1, add_ready ignored.
  - The next transaction (1.0, mode 0) is correct.
